// File: rtl/ctrl_pkg.sv
// ctrl_pkg : shared state encodings and trap causes for the control FSM slice.  Rev 1.0
`default_nettype none

package ctrl_pkg;

  localparam int ST_FETCH_B      = 0;
  localparam int ST_WAIT_INSTR_B = 1;
  localparam int ST_EXECUTE_B    = 2;
  localparam int ST_WAIT_UNIT_B  = 3;
  localparam int ST_FLUSH_B      = 4;
  localparam int ST_TRAP_B       = 5;
  localparam int NUM_STATES      = 6;

  typedef enum logic [NUM_STATES-1:0] {
    ST_FETCH      = 6'(1) << ST_FETCH_B,
    ST_WAIT_INSTR = 6'(1) << ST_WAIT_INSTR_B,
    ST_EXECUTE    = 6'(1) << ST_EXECUTE_B,
    ST_WAIT_UNIT  = 6'(1) << ST_WAIT_UNIT_B,
    ST_FLUSH      = 6'(1) << ST_FLUSH_B,
    ST_TRAP       = 6'(1) << ST_TRAP_B
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL   = 2'd0,
    CAUSE_IFETCH_TO = 2'd1,
    CAUSE_DMEM_TO   = 2'd2,
    CAUSE_IRQ       = 2'd3
  } cause_e;

  function automatic logic is_wait_state(input state_e s);
    return (s == ST_WAIT_INSTR) || (s == ST_WAIT_UNIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_timeout_cnt.sv
// ctrl_timeout_cnt : saturating response-wait counter, expired flags the last allowed cycle.  Rev 1.0
`default_nettype none

module ctrl_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] FIRE  = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_q <= count_q + CW'(1);
    end
  end

  // The caller decides whether a same-cycle response overrides this.
  assign expired = enable && (count_q == FIRE);

endmodule

`default_nettype wire

// File: rtl/ctrl_fsm_gen2.sv
// ctrl_fsm_gen2 : fetch/execute/wait control FSM with traps; perf counters under CTRL_FSM_PERF_CNT_EN.  Rev 1.0
`default_nettype none

module ctrl_fsm_gen2
  import ctrl_pkg::*;
#(
  parameter int NUM_FU  = 2,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [NUM_FU-1:0] fu_sel,
  input  logic [NUM_FU-1:0] fu_busy,
  input  logic              icache_ready,
  input  logic              dcache_ready,
  input  logic              branch_mispredict,
  input  logic              illegal_instr,
  input  logic              irq,
  output logic              pc_load_en,
  output logic              icache_req,
  output logic              dcache_ren,
  output logic              dcache_wen,
  output logic              writeback_en,
  output logic [NUM_FU-1:0] fu_op_valid,
  output logic              trap_valid,
  output logic [1:0]        trap_cause,
  output logic [5:0]        state_out,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e            state_q, state_d, state_eff;
  cause_e            cause_q, cause_d;
  logic              wb_q, wb_d;
  logic              mem_op_q, load_op_q;
  logic [NUM_FU-1:0] fu_sel_q;
  logic              to_enable, to_clear, to_expired;
  logic              exec_ok, unit_done;

  // Outputs decode as FETCH while reset is held, whatever the register holds.
  assign state_eff = reset ? state_q : ST_FETCH;
  assign exec_ok   = (state_eff == ST_EXECUTE) && !illegal_instr;
  assign unit_done = ((fu_busy & fu_sel_q) == '0);

  assign to_enable = (state_q == ST_WAIT_INSTR) || ((state_q == ST_WAIT_UNIT) && mem_op_q);
  assign to_clear  = (state_d != state_q);

  ctrl_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (to_expired)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    wb_d    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (irq) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IRQ;
        end else begin
          state_d = ST_WAIT_INSTR;
        end
      end
      ST_WAIT_INSTR: begin
        if (icache_ready) begin
          state_d = ST_EXECUTE;
        end else if (to_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IFETCH_TO;
        end
      end
      ST_EXECUTE: begin
        if (illegal_instr) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (branch_mispredict) begin
          state_d = ST_FLUSH;
        end else if (is_load || is_store || (|fu_sel)) begin
          state_d = ST_WAIT_UNIT;
        end else begin
          state_d = ST_FETCH;
          wb_d    = 1'b1;
        end
      end
      ST_WAIT_UNIT: begin
        // A memory op waits on the data cache even if a unit was also selected.
        if (mem_op_q) begin
          if (dcache_ready) begin
            state_d = ST_FETCH;
            wb_d    = load_op_q;
          end else if (to_expired) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_DMEM_TO;
          end
        end else if (unit_done) begin
          state_d = ST_FETCH;
          wb_d    = 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_FETCH;
      ST_TRAP:  state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      cause_q   <= CAUSE_ILLEGAL;
      wb_q      <= 1'b0;
      mem_op_q  <= 1'b0;
      load_op_q <= 1'b0;
      fu_sel_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wb_q    <= wb_d;
      if (state_q == ST_EXECUTE) begin
        mem_op_q  <= is_load || is_store;
        load_op_q <= is_load;
        fu_sel_q  <= fu_sel;
      end
    end
  end

  assign icache_req   = (state_eff == ST_FETCH);
  assign pc_load_en   = exec_ok || (state_eff == ST_FLUSH) || (state_eff == ST_TRAP);
  assign dcache_ren   = exec_ok && is_load;
  assign dcache_wen   = exec_ok && is_store;
  assign fu_op_valid  = {NUM_FU{exec_ok}} & fu_sel;
  assign trap_valid   = (state_eff == ST_TRAP);
  assign trap_cause   = cause_q;
  assign writeback_en = wb_q;
  assign state_out    = state_eff;

`ifdef CTRL_FSM_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q, stall_cnt_q;

  // Retired instructions are counted on the same edge that raises writeback_en.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (wb_d) begin
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
      if (is_wait_state(state_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: doc/ctrl_fsm_gen2.md
CTRL_FSM_GEN2 -- requirements
Module: ctrl_fsm_gen2

Interface
REQ-001 Parameter NUM_FU, default 2: number of long-latency functional units (1..8).
REQ-002 Parameter TIMEOUT, default 255: maximum wait cycles on an icache or dcache response before a trap.
REQ-003 Parameter CNT_W, default 32: performance counter width.
REQ-004 clk  in  1  clock; reset is synchronous, active-low, named reset.
REQ-005 reset  in  1  synchronous active-low reset.
REQ-006 is_load, is_store  in  1 each  decoded memory op.
REQ-007 fu_sel  in  NUM_FU  one-hot long-latency unit select; all-zero means single-cycle op.
REQ-008 fu_busy  in  NUM_FU  per-unit busy.
REQ-009 icache_ready, dcache_ready  in  1 each  response valid.
REQ-010 branch_mispredict, illegal_instr, irq  in  1 each.
REQ-011 pc_load_en, icache_req, dcache_ren, dcache_wen, writeback_en  out  1 each.
REQ-012 fu_op_valid  out  NUM_FU  per-unit start pulse.
REQ-013 trap_valid  out  1; trap_cause  out  2: 0 = illegal, 1 = ifetch timeout, 2 = dmem timeout, 3 = irq.
REQ-014 state_out  out  6  one-hot state.
REQ-015 cycle_cnt, instr_cnt, stall_cnt  out  CNT_W each (see Configuration).

Function
REQ-016 States SHALL be FETCH, WAIT_INSTR, EXECUTE, WAIT_UNIT, FLUSH and TRAP, one-hot encoded.
REQ-017 FETCH SHALL assert icache_req for one cycle. If irq=1 in FETCH, the next state is TRAP with cause 3; otherwise it is WAIT_INSTR.
REQ-018 WAIT_INSTR SHALL go to EXECUTE on icache_ready, and to TRAP with cause 1 after TIMEOUT cycles without icache_ready.
REQ-019 EXECUTE SHALL be exactly one cycle. Transitions in priority order:
  - illegal_instr -> TRAP (cause 0)
  - branch_mispredict -> FLUSH
  - is_load | is_store | |fu_sel -> WAIT_UNIT
  - otherwise -> FETCH
REQ-020 In EXECUTE the following SHALL be combinational: pc_load_en=1, dcache_ren=is_load, dcache_wen=is_store, fu_op_valid=fu_sel. All are suppressed when illegal_instr=1.
REQ-021 WAIT_UNIT SHALL exit to FETCH:
  - for a memory op, on dcache_ready;
  - for a unit op, when fu_busy & fu_sel is zero (busy of unselected units is ignored).
REQ-022 A memory op in WAIT_UNIT SHALL go to TRAP with cause 2 after TIMEOUT cycles without dcache_ready. Unit ops SHALL have no timeout.
REQ-023 FLUSH SHALL assert pc_load_en and go to FETCH after one cycle.
REQ-024 TRAP SHALL assert pc_load_en and trap_valid for one cycle with trap_cause held, then go to FETCH.
REQ-025 writeback_en SHALL be registered, asserted one cycle after either:
  - EXECUTE of a non-waiting, legal, non-mispredicted op, or
  - WAIT_UNIT exit on a load or a unit op.
  It is never asserted for stores, traps or flushes.
REQ-026 The timeout counter SHALL clear on every state entry, saturate at TIMEOUT, and fire when the count equals TIMEOUT-1 with the response still absent. A response arriving in that same cycle wins.
REQ-027 If a response and irq are asserted in the same cycle, the response SHALL be honoured. irq is sampled only in FETCH.
REQ-028 An illegal state encoding SHALL recover to FETCH on the next cycle.

Reset
REQ-029 When reset=0: state=FETCH, writeback_en=0, trap_cause=0, timeout counter=0, performance counters=0.
REQ-030 Reset in any state, including mid-wait, SHALL take effect at the next clock edge, with no pending request or trap retained.
REQ-031 While reset=0, combinational outputs SHALL follow the FETCH state, so icache_req=1 in the first cycle after reset release.

Configuration
REQ-032 Macro CTRL_FSM_PERF_CNT_EN, when defined, SHALL enable the performance counters:
  - cycle_cnt counts every cycle;
  - instr_cnt counts each writeback_en pulse;
  - stall_cnt counts cycles in WAIT_INSTR or WAIT_UNIT;
  - all counters wrap modulo 2^CNT_W.
REQ-033 When CTRL_FSM_PERF_CNT_EN is undefined, the three counter outputs SHALL be tied to zero and no counter flops SHALL be inferred.

Structure
REQ-034 Shared package ctrl_pkg SHALL hold the state bit indices, the state one-hot constants and the trap_cause encodings.
REQ-035 Timeout logic SHALL be a sub-module ctrl_timeout_cnt (parameter TIMEOUT; ports clk, reset, clear, enable, expired).

Verification
REQ-036 Single-cycle op: icache_ready 2 cycles after icache_req, fu_sel=0 -> states FETCH, WAIT_INSTR×2, EXECUTE, FETCH; writeback_en high 1 cycle after EXECUTE.
REQ-037 Unit op, NUM_FU=2: fu_sel=2'b10, fu_busy=2'b11 for 5 cycles then 2'b01 -> fu_op_valid=2'b10 for one cycle; WAIT_UNIT exits when bit 1 clears; writeback_en pulses once.
REQ-038 Load, TIMEOUT=4: dcache_ready never asserted -> TRAP after 4 WAIT_UNIT cycles with trap_cause=2, trap_valid 1 cycle, no writeback_en. Repeat with dcache_ready in the 4th cycle -> FETCH, writeback_en=1.
REQ-039 EXECUTE with illegal_instr=1 and branch_mispredict=1 -> TRAP with cause 0; dcache_ren, dcache_wen and fu_op_valid stay 0.
REQ-040 irq=1 in FETCH -> TRAP with cause 3, then FETCH. Reset asserted in WAIT_UNIT -> FETCH with counters at 0.
REQ-041 With CTRL_FSM_PERF_CNT_EN defined, 10 single-cycle instructions at 1-cycle icache latency -> instr_cnt=10, stall_cnt=10, cycle_cnt=30.
